// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared encodings for the RV32I multi-cycle controller: immediate
//            format codes, opcode constants, PC/writeback mux codes,
//            instruction classes and FSM states.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

   // Immediate generator format select
   localparam logic [2:0] c_imm_none = 3'd0;
   localparam logic [2:0] c_imm_i    = 3'd1;
   localparam logic [2:0] c_imm_s    = 3'd2;
   localparam logic [2:0] c_imm_b    = 3'd3;
   localparam logic [2:0] c_imm_u    = 3'd4;
   localparam logic [2:0] c_imm_j    = 3'd5;

   // RV32I base opcodes (inst[6:0])
   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;
   localparam logic [6:0] c_opc_jal    = 7'b1101111;
   localparam logic [6:0] c_opc_jalr   = 7'b1100111;
   localparam logic [6:0] c_opc_branch = 7'b1100011;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_op     = 7'b0110011;

   // PC source select
   localparam logic [1:0] c_pc_sel_plus4   = 2'd0;
   localparam logic [1:0] c_pc_sel_alu     = 2'd1;
   localparam logic [1:0] c_pc_sel_alu_clr = 2'd2;

   // Register file writeback select
   localparam logic [1:0] c_wb_sel_alu = 2'd0;
   localparam logic [1:0] c_wb_sel_mdr = 2'd1;
   localparam logic [1:0] c_wb_sel_pc4 = 2'd2;
   localparam logic [1:0] c_wb_sel_imm = 2'd3;

   typedef enum logic [3:0] {
      CLS_ILLEGAL = 4'd0,
      CLS_OP      = 4'd1,
      CLS_OP_IMM  = 4'd2,
      CLS_LUI     = 4'd3,
      CLS_AUIPC   = 4'd4,
      CLS_BRANCH  = 4'd5,
      CLS_JAL     = 4'd6,
      CLS_JALR    = 4'd7,
      CLS_LOAD    = 4'd8,
      CLS_STORE   = 4'd9
   } inst_class_t;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   function automatic logic [6:0] opcode_of(input logic [31:0] inst);
      return inst[6:0];
   endfunction

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_if
// Purpose  : Bundle between the multi-cycle controller and the datapath.
//            master = controller side, slave = datapath side.
// Signals  : inst, mem_ready, br_cond     (datapath -> controller)
//            mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, imm_sel,
//            alu_a_sel, alu_b_sel, alu_add, rf_we, wb_sel, illegal
//                                          (controller -> datapath)
// Revision : 1.0  initial release
// ============================================================================
interface mc_ctrl_if;
   import mc_ctrl_pkg::*;

   logic [31:0] inst;
   logic        mem_ready;
   logic        br_cond;

   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  pc_sel;
   logic [2:0]  imm_sel;
   logic        alu_a_sel;
   logic        alu_b_sel;
   logic        alu_add;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        illegal;

   modport master (
      input  inst, mem_ready, br_cond,
      output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, imm_sel,
             alu_a_sel, alu_b_sel, alu_add, rf_we, wb_sel, illegal
   );

   modport slave (
      output inst, mem_ready, br_cond,
      input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, imm_sel,
             alu_a_sel, alu_b_sel, alu_add, rf_we, wb_sel, illegal
   );

endinterface : mc_ctrl_if
`default_nettype wire

// File: rtl/mc_ctrl_inst_class_dec.sv
`default_nettype none
// ============================================================================
// Module   : inst_class_dec
// Purpose  : Combinational opcode classifier. Maps the opcode field of the
//            instruction to an instruction class, the immediate format and
//            an illegal-opcode flag.
// Ports    : i_inst     in   32  instruction register contents
//            o_cls      out  4   instruction class
//            o_imm_sel  out  3   immediate format select
//            o_illegal  out  1   opcode is not part of RV32I as supported
// Revision : 1.0  initial release
// ============================================================================
module inst_class_dec
   import mc_ctrl_pkg::*;
(
   input  logic [31:0]  i_inst,
   output inst_class_t  o_cls,
   output logic [2:0]   o_imm_sel,
   output logic         o_illegal
);

   // Only the opcode field matters for classification.
   logic w_unused_inst_bits;
   assign w_unused_inst_bits = ^i_inst[31:7];

   always_comb begin
      o_cls     = CLS_ILLEGAL;
      o_imm_sel = c_imm_none;
      o_illegal = 1'b0;
      case (opcode_of(i_inst))
         c_opc_op: begin
            o_cls = CLS_OP;
         end
         c_opc_op_imm: begin
            o_cls     = CLS_OP_IMM;
            o_imm_sel = c_imm_i;
         end
         c_opc_lui: begin
            o_cls     = CLS_LUI;
            o_imm_sel = c_imm_u;
         end
         c_opc_auipc: begin
            o_cls     = CLS_AUIPC;
            o_imm_sel = c_imm_u;
         end
         c_opc_branch: begin
            o_cls     = CLS_BRANCH;
            o_imm_sel = c_imm_b;
         end
         c_opc_jal: begin
            o_cls     = CLS_JAL;
            o_imm_sel = c_imm_j;
         end
         c_opc_jalr: begin
            o_cls     = CLS_JALR;
            o_imm_sel = c_imm_i;
         end
         c_opc_load: begin
            o_cls     = CLS_LOAD;
            o_imm_sel = c_imm_i;
         end
         c_opc_store: begin
            o_cls     = CLS_STORE;
            o_imm_sel = c_imm_s;
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule : inst_class_dec
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle control FSM for the RV32I core. Sequences
//            FETCH / DECODE / EXEC / MEM / WB and drives the datapath
//            muxes, write enables and the memory request handshake.
// Params   : TRAP_EN  1: illegal opcode halts in TRAP
//                     0: illegal opcode retires as a NOP (PC+4)
// Ports    : clk   in   1   clock, rising edge
//            rst   in   1   synchronous reset, active-high
//            bus   master modport of mc_ctrl_if
//                  (inst, mem_ready, br_cond in; memory handshake, mux
//                   selects, write enables and illegal flag out)
// Revision : 1.0  initial release
// ============================================================================
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter bit TRAP_EN = 1'b1
)(
   input  logic      clk,
   input  logic      rst,
   mc_ctrl_if.master bus
);

   state_t      r_state;
   state_t      w_state_nxt;

   inst_class_t w_cls;
   logic [2:0]  w_imm_dec;
   logic        w_illegal_opc;

   logic        w_mem_req;
   logic        w_mem_we;
   logic        w_addr_sel;
   logic        w_ir_we;
   logic        w_pc_we;
   logic [1:0]  w_pc_sel;
   logic [2:0]  w_imm_sel;
   logic        w_alu_a_sel;
   logic        w_alu_b_sel;
   logic        w_alu_add;
   logic        w_rf_we;
   logic [1:0]  w_wb_sel;
   logic        w_illegal;

   inst_class_dec u_dec (
      .i_inst    (bus.inst),
      .o_cls     (w_cls),
      .o_imm_sel (w_imm_dec),
      .o_illegal (w_illegal_opc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_addr_sel  = 1'b0;
      w_ir_we     = 1'b0;
      w_pc_we     = 1'b0;
      w_pc_sel    = c_pc_sel_plus4;
      w_imm_sel   = c_imm_none;
      w_alu_a_sel = 1'b0;
      w_alu_b_sel = 1'b0;
      w_alu_add   = 1'b0;
      w_rf_we     = 1'b0;
      w_wb_sel    = c_wb_sel_alu;
      w_illegal   = 1'b0;

      case (r_state)
         ST_FETCH: begin
            // mem_req depends only on state, so it cannot drop before mem_ready.
            w_mem_req = 1'b1;
            if (bus.mem_ready) begin
               w_ir_we     = 1'b1;
               w_state_nxt = ST_DECODE;
            end
         end

         ST_DECODE: begin
            w_imm_sel = w_imm_dec;
            if (w_illegal_opc) begin
               if (TRAP_EN) begin
                  w_state_nxt = ST_TRAP;
               end else begin
                  w_pc_we     = 1'b1;
                  w_pc_sel    = c_pc_sel_plus4;
                  w_state_nxt = ST_FETCH;
               end
            end else begin
               w_state_nxt = ST_EXEC;
            end
         end

         ST_EXEC: begin
            w_imm_sel   = w_imm_dec;
            w_state_nxt = ST_FETCH;
            // PC+4 on the writeback mux is taken from the PC before this
            // cycle's update, so rd write and PC write can share the cycle.
            case (w_cls)
               CLS_OP: begin
                  w_rf_we  = 1'b1;
                  w_wb_sel = c_wb_sel_alu;
                  w_pc_we  = 1'b1;
               end
               CLS_OP_IMM: begin
                  w_alu_b_sel = 1'b1;
                  w_rf_we     = 1'b1;
                  w_wb_sel    = c_wb_sel_alu;
                  w_pc_we     = 1'b1;
               end
               CLS_AUIPC: begin
                  w_alu_a_sel = 1'b1;
                  w_alu_b_sel = 1'b1;
                  w_alu_add   = 1'b1;
                  w_rf_we     = 1'b1;
                  w_wb_sel    = c_wb_sel_alu;
                  w_pc_we     = 1'b1;
               end
               CLS_LUI: begin
                  w_rf_we  = 1'b1;
                  w_wb_sel = c_wb_sel_imm;
                  w_pc_we  = 1'b1;
               end
               CLS_BRANCH: begin
                  w_alu_a_sel = 1'b1;
                  w_alu_b_sel = 1'b1;
                  w_alu_add   = 1'b1;
                  w_pc_we     = 1'b1;
                  w_pc_sel    = bus.br_cond ? c_pc_sel_alu : c_pc_sel_plus4;
               end
               CLS_JAL: begin
                  w_alu_a_sel = 1'b1;
                  w_alu_b_sel = 1'b1;
                  w_alu_add   = 1'b1;
                  w_rf_we     = 1'b1;
                  w_wb_sel    = c_wb_sel_pc4;
                  w_pc_we     = 1'b1;
                  w_pc_sel    = c_pc_sel_alu;
               end
               CLS_JALR: begin
                  w_alu_b_sel = 1'b1;
                  w_alu_add   = 1'b1;
                  w_rf_we     = 1'b1;
                  w_wb_sel    = c_wb_sel_pc4;
                  w_pc_we     = 1'b1;
                  w_pc_sel    = c_pc_sel_alu_clr;
               end
               CLS_LOAD, CLS_STORE: begin
                  w_alu_b_sel = 1'b1;
                  w_alu_add   = 1'b1;
                  w_state_nxt = ST_MEM;
               end
               default: begin
                  // Illegal opcodes never reach EXEC; retire safely anyway.
                  w_state_nxt = ST_FETCH;
               end
            endcase
         end

         ST_MEM: begin
            // Address operands stay selected so the ALU result is stable
            // for the whole request.
            w_imm_sel   = w_imm_dec;
            w_mem_req   = 1'b1;
            w_addr_sel  = 1'b1;
            w_alu_b_sel = 1'b1;
            w_alu_add   = 1'b1;
            w_mem_we    = (w_cls == CLS_STORE);
            if (bus.mem_ready) begin
               if (w_cls == CLS_STORE) begin
                  w_pc_we     = 1'b1;
                  w_pc_sel    = c_pc_sel_plus4;
                  w_state_nxt = ST_FETCH;
               end else begin
                  w_state_nxt = ST_WB;
               end
            end
         end

         ST_WB: begin
            w_imm_sel   = w_imm_dec;
            w_rf_we     = 1'b1;
            w_wb_sel    = c_wb_sel_mdr;
            w_pc_we     = 1'b1;
            w_pc_sel    = c_pc_sel_plus4;
            w_state_nxt = ST_FETCH;
         end

         ST_TRAP: begin
            w_illegal   = 1'b1;
            w_state_nxt = ST_TRAP;
         end

         default: begin
            w_state_nxt = ST_FETCH;
         end
      endcase

      // Reset masks every output in the same cycle, including a pending
      // memory request.
      if (rst) begin
         w_mem_req   = 1'b0;
         w_mem_we    = 1'b0;
         w_addr_sel  = 1'b0;
         w_ir_we     = 1'b0;
         w_pc_we     = 1'b0;
         w_pc_sel    = c_pc_sel_plus4;
         w_imm_sel   = c_imm_none;
         w_alu_a_sel = 1'b0;
         w_alu_b_sel = 1'b0;
         w_alu_add   = 1'b0;
         w_rf_we     = 1'b0;
         w_wb_sel    = c_wb_sel_alu;
         w_illegal   = 1'b0;
      end
   end

   assign bus.mem_req   = w_mem_req;
   assign bus.mem_we    = w_mem_we;
   assign bus.addr_sel  = w_addr_sel;
   assign bus.ir_we     = w_ir_we;
   assign bus.pc_we     = w_pc_we;
   assign bus.pc_sel    = w_pc_sel;
   assign bus.imm_sel   = w_imm_sel;
   assign bus.alu_a_sel = w_alu_a_sel;
   assign bus.alu_b_sel = w_alu_b_sel;
   assign bus.alu_add   = w_alu_add;
   assign bus.rf_we     = w_rf_we;
   assign bus.wb_sel    = w_wb_sel;
   assign bus.illegal   = w_illegal;

endmodule : mc_ctrl
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Self-checking bench for mc_ctrl. Two instances: TRAP_EN=1 and
//            TRAP_EN=0, fed identical inputs. Each output vector is packed as
//            {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel[1:0],
//             imm_sel[2:0], alu_a_sel, alu_b_sel, alu_add, rf_we,
//             wb_sel[1:0], illegal}.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

   localparam logic [31:0] c_addi  = 32'h00500093;
   localparam logic [31:0] c_lw    = 32'h0000A103;
   localparam logic [31:0] c_beq   = 32'h00000463;
   localparam logic [31:0] c_jal   = 32'h008000EF;
   localparam logic [31:0] c_jalr  = 32'h000080E7;
   localparam logic [31:0] c_sw    = 32'h00112023;
   localparam logic [31:0] c_lui   = 32'h123450B7;
   localparam logic [31:0] c_auipc = 32'h00001097;
   localparam logic [31:0] c_add   = 32'h002081B3;
   localparam logic [31:0] c_bad   = 32'hFFFFFFFF;

   typedef struct {
      logic        r;
      logic [31:0] ins;
      logic        rdy;
      logic        br;
      logic [16:0] exp;
   } stim_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mc_ctrl_if bus0 ();
   mc_ctrl_if bus1 ();

   mc_ctrl #(.TRAP_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
   mc_ctrl #(.TRAP_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

   logic [16:0] v0, v1;
   assign v0 = {bus0.mem_req, bus0.mem_we, bus0.addr_sel, bus0.ir_we, bus0.pc_we,
                bus0.pc_sel, bus0.imm_sel, bus0.alu_a_sel, bus0.alu_b_sel,
                bus0.alu_add, bus0.rf_we, bus0.wb_sel, bus0.illegal};
   assign v1 = {bus1.mem_req, bus1.mem_we, bus1.addr_sel, bus1.ir_we, bus1.pc_we,
                bus1.pc_sel, bus1.imm_sel, bus1.alu_a_sel, bus1.alu_b_sel,
                bus1.alu_add, bus1.rf_we, bus1.wb_sel, bus1.illegal};

   int          total = 0;
   int          bad   = 0;
   stim_t       plan[$];
   logic [16:0] sb[$];

   // Expected output vector builder (field order as in the header).
   function automatic logic [16:0] ov(input int req, input int we, input int as,
                                      input int ir, input int pw, input int ps,
                                      input int im, input int aa, input int bb,
                                      input int ad, input int rf, input int wb,
                                      input int il);
      return {req[0], we[0], as[0], ir[0], pw[0], ps[1:0], im[2:0],
              aa[0], bb[0], ad[0], rf[0], wb[1:0], il[0]};
   endfunction

   function automatic logic [16:0] fetch_wait();
      return ov(1,0,0,0,0,0,0,0,0,0,0,0,0);
   endfunction

   function automatic logic [16:0] fetch_go();
      return ov(1,0,0,1,0,0,0,0,0,0,0,0,0);
   endfunction

   function automatic logic [16:0] decode(input int im);
      return ov(0,0,0,0,0,0,im,0,0,0,0,0,0);
   endfunction

   task automatic add(input int r, input logic [31:0] ins, input int rdy,
                      input int br, input logic [16:0] exp);
      stim_t s;
      s.r   = r[0];
      s.ins = ins;
      s.rdy = rdy[0];
      s.br  = br[0];
      s.exp = exp;
      plan.push_back(s);
   endtask

   // Applies one cycle of stimulus after the edge; the expectation goes into
   // the scoreboard and is popped when outputs are sampled at the negedge.
   task automatic drive(input stim_t s);
      @(posedge clk);
      #1;
      rst            = s.r;
      bus0.inst      = s.ins;
      bus1.inst      = s.ins;
      bus0.mem_ready = s.rdy;
      bus1.mem_ready = s.rdy;
      bus0.br_cond   = s.br;
      bus1.br_cond   = s.br;
      sb.push_back(s.exp);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [16:0] e;
      int          cyc = 0;
      add(1, c_addi, 1, 1, 17'h0);
      add(1, c_addi, 1, 1, 17'h0);
      add(0, c_addi, 0, 0, fetch_wait());
      add(0, c_addi, 0, 0, fetch_wait());
      while (plan.size() > 0) begin
         drive(plan.pop_front());
         e = sb.pop_front();
         total++;
         if (v0 !== e) begin
            $display("FAIL reset cyc%0d got=%h exp=%h", cyc, v0, e);
            bad++;
         end
         cyc++;
      end
   endtask

   task automatic test_alu();
      logic [16:0] e;
      int          cyc = 0;
      add(1, c_addi, 1, 0, 17'h0);
      add(0, c_addi, 1, 0, fetch_go());
      add(0, c_addi, 1, 0, decode(1));
      add(0, c_addi, 1, 0, ov(0,0,0,0,1,0,1,0,1,0,1,0,0));
      add(0, c_addi, 0, 0, fetch_wait());
      while (plan.size() > 0) begin
         drive(plan.pop_front());
         e = sb.pop_front();
         total++;
         if (v0 !== e) begin
            $display("FAIL alu_addi cyc%0d got=%h exp=%h", cyc, v0, e);
            bad++;
         end
         cyc++;
      end
   endtask

   task automatic test_load();
      logic [16:0] e;
      int          cyc = 0;
      add(1, c_lw, 0, 0, 17'h0);
      add(0, c_lw, 1, 0, fetch_go());
      add(0, c_lw, 0, 0, decode(1));
      add(0, c_lw, 0, 0, ov(0,0,0,0,0,0,1,0,1,1,0,0,0));
      for (int i = 0; i < 3; i++)
         add(0, c_lw, 0, 0, ov(1,0,1,0,0,0,1,0,1,1,0,0,0));
      add(0, c_lw, 1, 0, ov(1,0,1,0,0,0,1,0,1,1,0,0,0));
      add(0, c_lw, 0, 0, ov(0,0,0,0,1,0,1,0,0,0,1,1,0));
      add(0, c_lw, 0, 0, fetch_wait());
      while (plan.size() > 0) begin
         drive(plan.pop_front());
         e = sb.pop_front();
         total++;
         if (v0 !== e) begin
            $display("FAIL load cyc%0d got=%h exp=%h", cyc, v0, e);
            bad++;
         end
         cyc++;
      end
   endtask

   task automatic test_branch();
      logic [16:0] e;
      int          cyc = 0;
      add(1, c_beq, 0, 0, 17'h0);
      for (int b = 1; b >= 0; b--) begin
         add(0, c_beq, 1, b, fetch_go());
         add(0, c_beq, 0, b, decode(3));
         add(0, c_beq, 0, b, ov(0,0,0,0,1,b,3,1,1,1,0,0,0));
      end
      add(0, c_beq, 0, 0, fetch_wait());
      while (plan.size() > 0) begin
         drive(plan.pop_front());
         e = sb.pop_front();
         total++;
         if (v0 !== e) begin
            $display("FAIL branch cyc%0d got=%h exp=%h", cyc, v0, e);
            bad++;
         end
         cyc++;
      end
   endtask

   task automatic test_jump();
      logic [16:0] e;
      int          cyc = 0;
      add(1, c_jal, 0, 0, 17'h0);
      add(0, c_jal, 1, 0, fetch_go());
      add(0, c_jal, 0, 0, decode(5));
      add(0, c_jal, 0, 0, ov(0,0,0,0,1,1,5,1,1,1,1,2,0));
      add(0, c_jalr, 1, 0, fetch_go());
      add(0, c_jalr, 0, 0, decode(1));
      add(0, c_jalr, 0, 0, ov(0,0,0,0,1,2,1,0,1,1,1,2,0));
      add(0, c_jalr, 0, 0, fetch_wait());
      while (plan.size() > 0) begin
         drive(plan.pop_front());
         e = sb.pop_front();
         total++;
         if (v0 !== e) begin
            $display("FAIL jump cyc%0d got=%h exp=%h", cyc, v0, e);
            bad++;
         end
         cyc++;
      end
   endtask

   task automatic test_store();
      logic [16:0] e;
      int          cyc = 0;
      add(1, c_sw, 0, 0, 17'h0);
      add(0, c_sw, 1, 0, fetch_go());
      add(0, c_sw, 0, 0, decode(2));
      add(0, c_sw, 0, 0, ov(0,0,0,0,0,0,2,0,1,1,0,0,0));
      add(0, c_sw, 0, 0, ov(1,1,1,0,0,0,2,0,1,1,0,0,0));
      add(0, c_sw, 1, 0, ov(1,1,1,0,1,0,2,0,1,1,0,0,0));
      // second store, interrupted by reset while the request is pending
      add(0, c_sw, 1, 0, fetch_go());
      add(0, c_sw, 0, 0, decode(2));
      add(0, c_sw, 0, 0, ov(0,0,0,0,0,0,2,0,1,1,0,0,0));
      add(0, c_sw, 0, 0, ov(1,1,1,0,0,0,2,0,1,1,0,0,0));
      add(1, c_sw, 0, 0, 17'h0);
      add(0, c_sw, 0, 0, fetch_wait());
      while (plan.size() > 0) begin
         drive(plan.pop_front());
         e = sb.pop_front();
         total++;
         if (v0 !== e) begin
            $display("FAIL store cyc%0d got=%h exp=%h", cyc, v0, e);
            bad++;
         end
         cyc++;
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] e;
      int          cyc = 0;
      add(1, c_lui, 0, 0, 17'h0);
      add(0, c_lui, 1, 0, fetch_go());
      add(0, c_lui, 1, 0, decode(4));
      add(0, c_lui, 1, 0, ov(0,0,0,0,1,0,4,0,0,0,1,3,0));
      add(0, c_auipc, 1, 0, fetch_go());
      add(0, c_auipc, 1, 0, decode(4));
      add(0, c_auipc, 1, 0, ov(0,0,0,0,1,0,4,1,1,1,1,0,0));
      add(0, c_add, 1, 0, fetch_go());
      add(0, c_add, 1, 0, decode(0));
      add(0, c_add, 1, 0, ov(0,0,0,0,1,0,0,0,0,0,1,0,0));
      add(0, c_add, 0, 0, fetch_wait());
      while (plan.size() > 0) begin
         drive(plan.pop_front());
         e = sb.pop_front();
         total++;
         if (v0 !== e) begin
            $display("FAIL back_to_back cyc%0d got=%h exp=%h", cyc, v0, e);
            bad++;
         end
         cyc++;
      end
   endtask

   task automatic test_trap();
      logic [16:0] e;
      int          cyc = 0;
      add(1, c_bad, 0, 0, 17'h0);
      add(0, c_bad, 1, 0, fetch_go());
      add(0, c_bad, 1, 0, 17'h0);
      for (int i = 0; i < 5; i++)
         add(0, c_bad, 1, 0, ov(0,0,0,0,0,0,0,0,0,0,0,0,1));
      add(1, c_bad, 1, 0, 17'h0);
      add(0, c_bad, 0, 0, fetch_wait());
      while (plan.size() > 0) begin
         drive(plan.pop_front());
         e = sb.pop_front();
         total++;
         if (v0 !== e) begin
            $display("FAIL trap cyc%0d got=%h exp=%h", cyc, v0, e);
            bad++;
         end
         cyc++;
      end
   endtask

   task automatic test_trap_disabled();
      logic [16:0] e;
      int          cyc = 0;
      add(1, c_bad, 0, 0, 17'h0);
      add(0, c_bad, 1, 0, fetch_go());
      add(0, c_bad, 1, 0, ov(0,0,0,0,1,0,0,0,0,0,0,0,0));
      add(0, c_bad, 0, 0, fetch_wait());
      add(0, c_bad, 0, 0, fetch_wait());
      while (plan.size() > 0) begin
         drive(plan.pop_front());
         e = sb.pop_front();
         total++;
         if (v1 !== e) begin
            $display("FAIL trap_disabled cyc%0d got=%h exp=%h", cyc, v1, e);
            bad++;
         end
         cyc++;
      end
   endtask

   initial begin
      bus0.inst      = 32'h0;
      bus1.inst      = 32'h0;
      bus0.mem_ready = 1'b0;
      bus1.mem_ready = 1'b0;
      bus0.br_cond   = 1'b0;
      bus1.br_cond   = 1'b0;
      test_reset();
      test_alu();
      test_load();
      test_branch();
      test_jump();
      test_store();
      test_back_to_back();
      test_trap();
      test_trap_disabled();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mc_ctrl
`default_nettype wire
